// File: rtl/imm_gen_stage.sv
// Immediate-generation decode stage: RISC-V format decode, XLEN sign-extension,
// PC+imm, registered output with a 2-entry skid buffer and registered in_ready.
module imm_gen_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } res_t;

  localparam res_t RES_RST = '{imm: '0, target: '0, fmt: FMT_NONE, illegal: 1'b0};

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e      r_state, w_state_nxt;
  res_t        r_out, r_skid, w_dec;
  logic        r_in_ready;
  logic [2:0]  w_fmt;
  logic [31:0] w_imm32;
  logic        w_in_fire, w_out_fire;
  logic        w_load_out, w_load_skid, w_skid_to_out;

  // W-suffixed opcodes only exist on RV64
  always_comb begin
    w_fmt = FMT_NONE;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
      7'b0011011: if (XLEN == 64) w_fmt = FMT_I;
      7'b0100011:                 w_fmt = FMT_S;
      7'b1100011:                 w_fmt = FMT_B;
      7'b0110111, 7'b0010111:     w_fmt = FMT_U;
      7'b0110011:                 w_fmt = FMT_R;
      7'b0111011: if (XLEN == 64) w_fmt = FMT_R;
      7'b1101111:                 w_fmt = FMT_J;
      default:                    w_fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {in_instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  always_comb begin
    w_dec         = RES_RST;
    w_dec.imm     = XLEN'($signed(w_imm32));
    w_dec.target  = in_pc + w_dec.imm;
    w_dec.fmt     = w_fmt;
    w_dec.illegal = (w_fmt == FMT_NONE);
  end

  assign out_valid  = (r_state != S_EMPTY);
  assign in_ready   = r_in_ready;
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      S_EMPTY: if (w_in_fire) begin
        w_state_nxt = S_ONE;
        w_load_out  = 1'b1;
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) w_load_out = 1'b1;
        else if (w_in_fire) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) w_state_nxt = S_EMPTY;
      end
      S_FULL: if (w_out_fire) begin
        w_state_nxt   = S_ONE;
        w_skid_to_out = 1'b1;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // flush wins over any fire in the same cycle
    if (flush) begin
      w_state_nxt   = S_EMPTY;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= RES_RST;
      r_skid <= RES_RST;
    end else begin
      if (w_load_out)         r_out <= w_dec;
      else if (w_skid_to_out) r_out <= r_skid;
      if (w_load_skid)        r_skid <= w_dec;
    end
  end

  assign out_imm     = r_out.imm;
  assign out_target  = r_out.target;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=64 and XLEN=32 instances share stimulus and are
// checked against an arithmetic reference model and a FIFO occupancy scoreboard.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;
  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        ill32;
  } exp_t;

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_target(tgt64),
    .out_fmt(fmt64), .out_illegal(ill64)
  );

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_target(tgt32),
    .out_fmt(fmt32), .out_illegal(ill32)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sx(input longint unsigned v, input int bits);
    if (v >= (64'd1 << (bits - 1))) return longint'(v) - longint'(64'd1 << bits);
    return longint'(v);
  endfunction

  // Reference: field extraction by shifting/masking, sign by signed-range arithmetic
  function automatic void ref_one(input logic [31:0] ins, input logic [63:0] pc, input bit x64,
                                  output logic [63:0] imm, output logic [63:0] tgt,
                                  output logic [2:0] fmt, output logic ill);
    longint unsigned w = {32'b0, ins};
    longint s = 0;
    logic [63:0] mask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    logic [6:0] op = ins[6:0];
    fmt = 3'd7;
    case (op)
      7'h03, 7'h13, 7'h67, 7'h73: fmt = 3'd1;
      7'h1B: if (x64) fmt = 3'd1;
      7'h23: fmt = 3'd2;
      7'h63: fmt = 3'd3;
      7'h37, 7'h17: fmt = 3'd4;
      7'h33: fmt = 3'd0;
      7'h3B: if (x64) fmt = 3'd0;
      7'h6F: fmt = 3'd5;
      default: fmt = 3'd7;
    endcase
    case (fmt)
      3'd1: s = sx((w >> 20) & 'hFFF, 12);
      3'd2: s = sx((((w >> 25) & 'h7F) << 5) | ((w >> 7) & 'h1F), 12);
      3'd3: s = sx((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                   (((w >> 25) & 'h3F) << 5) | (((w >> 8) & 'hF) << 1), 13);
      3'd4: s = sx(w & 'hFFFFF000, 32);
      3'd5: s = sx((((w >> 31) & 1) << 20) | (((w >> 12) & 'hFF) << 12) |
                   (((w >> 20) & 1) << 11) | (((w >> 21) & 'h3FF) << 1), 21);
      default: s = 0;
    endcase
    ill = (fmt == 3'd7);
    imm = 64'(s) & mask;
    tgt = (pc + 64'(s)) & mask;
  endfunction

  function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] pc);
    exp_t e;
    logic [63:0] i, t;
    logic [2:0] f;
    logic l;
    ref_one(ins, pc, 1'b1, i, t, f, l);
    e.imm64 = i; e.tgt64 = t; e.fmt64 = f; e.ill64 = l;
    ref_one(ins, pc, 1'b0, i, t, f, l);
    e.imm32 = i[31:0]; e.tgt32 = t[31:0]; e.fmt32 = f; e.ill32 = l;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0] op;
    case ($urandom_range(0, 12))
      0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h67;  3: op = 7'h73;
      4: op = 7'h1B;  5: op = 7'h23;  6: op = 7'h63;  7: op = 7'h37;
      8: op = 7'h17;  9: op = 7'h33;  10: op = 7'h3B; 11: op = 7'h6F;
      default: op = 7'($urandom);
    endcase
    return {r[31:7], op};
  endfunction

  task automatic test_reset();
    n_checks++;
    if ({ov64, rdy64, imm64, tgt64, fmt64, ill64} !== {1'b0, 1'b1, 64'h0, 64'h0, 3'd7, 1'b0})
      $display("FAIL reset64 got v=%b r=%b imm=%h tgt=%h fmt=%0d ill=%b", ov64, rdy64, imm64, tgt64, fmt64, ill64);
    else n_pass++;
    n_checks++;
    if ({ov32, rdy32, imm32, tgt32, fmt32, ill32} !== {1'b0, 1'b1, 32'h0, 32'h0, 3'd7, 1'b0})
      $display("FAIL reset32 got v=%b r=%b imm=%h tgt=%h fmt=%0d ill=%b", ov32, rdy32, imm32, tgt32, fmt32, ill32);
    else n_pass++;
  endtask

  task automatic test_directed();
    exp_t d[9];
    logic [31:0] ins[9];
    logic [63:0] pc[9];
    ins[0] = 32'hFFF00093; pc[0] = 64'h100;
    d[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 3'd1, 1'b0, 32'hFFFF_FFFF, 32'hFF, 3'd1, 1'b0};
    ins[1] = 32'hFE112E23; pc[1] = 64'h200;
    d[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h1FC, 3'd2, 1'b0, 32'hFFFF_FFFC, 32'h1FC, 3'd2, 1'b0};
    ins[2] = 32'hFE000CE3; pc[2] = 64'h1000;
    d[2] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFF8, 3'd3, 1'b0, 32'hFFFF_FFF8, 32'hFF8, 3'd3, 1'b0};
    ins[3] = 32'h800002B7; pc[3] = 64'h300;
    d[3] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0300, 3'd4, 1'b0, 32'h8000_0000, 32'h8000_0300, 3'd4, 1'b0};
    ins[4] = 32'h001000EF; pc[4] = 64'h2000;
    d[4] = '{64'h800, 64'h2800, 3'd5, 1'b0, 32'h800, 32'h2800, 3'd5, 1'b0};
    ins[5] = 32'h0000007F; pc[5] = 64'h400;
    d[5] = '{64'h0, 64'h400, 3'd7, 1'b1, 32'h0, 32'h400, 3'd7, 1'b1};
    ins[6] = 32'h0000003B; pc[6] = 64'h500;
    d[6] = '{64'h0, 64'h500, 3'd0, 1'b0, 32'h0, 32'h500, 3'd7, 1'b1};
    ins[7] = 32'h00208033; pc[7] = 64'h600;
    d[7] = '{64'h0, 64'h600, 3'd0, 1'b0, 32'h0, 32'h600, 3'd0, 1'b0};
    ins[8] = 32'hFFF0001B; pc[8] = 64'h700;
    d[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h6FF, 3'd1, 1'b0, 32'h0, 32'h700, 3'd7, 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; in_instr = ins[k]; in_pc = pc[k];
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({ov64, ov32} !== 2'b11) $display("FAIL dir_latency[%0d] got v64=%b v32=%b want 1", k, ov64, ov32);
      else n_pass++;
      n_checks++;
      if ({imm64, tgt64, fmt64, ill64} !== {d[k].imm64, d[k].tgt64, d[k].fmt64, d[k].ill64})
        $display("FAIL dir64[%0d] got imm=%h tgt=%h fmt=%0d ill=%b want imm=%h tgt=%h fmt=%0d ill=%b",
                 k, imm64, tgt64, fmt64, ill64, d[k].imm64, d[k].tgt64, d[k].fmt64, d[k].ill64);
      else n_pass++;
      n_checks++;
      if ({imm32, tgt32, fmt32, ill32} !== {d[k].imm32, d[k].tgt32, d[k].fmt32, d[k].ill32})
        $display("FAIL dir32[%0d] got imm=%h tgt=%h fmt=%0d ill=%b want imm=%h tgt=%h fmt=%0d ill=%b",
                 k, imm32, tgt32, fmt32, ill32, d[k].imm32, d[k].tgt32, d[k].fmt32, d[k].ill32);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_backpressure();
    exp_t e[3];
    logic [31:0] ins[3];
    logic [63:0] pc[3];
    ins[0] = 32'hFFF00093; pc[0] = 64'h100;
    ins[1] = 32'hFE000CE3; pc[1] = 64'h1000;
    ins[2] = 32'h001000EF; pc[2] = 64'h2000;
    for (int k = 0; k < 3; k++) e[k] = ref_model(ins[k], pc[k]);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = ins[0]; in_pc = pc[0];
    step();
    n_checks++;
    if ({ov64, rdy64, imm64, tgt64} !== {1'b1, 1'b1, e[0].imm64, e[0].tgt64})
      $display("FAIL bp_first got v=%b r=%b imm=%h tgt=%h", ov64, rdy64, imm64, tgt64);
    else n_pass++;
    in_instr = ins[1]; in_pc = pc[1];
    step();
    in_instr = ins[2]; in_pc = pc[2];
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({rdy64, rdy32, ov64, imm64, tgt64, fmt64, imm32, fmt32} !==
          {1'b0, 1'b0, 1'b1, e[0].imm64, e[0].tgt64, e[0].fmt64, e[0].imm32, e[0].fmt32})
        $display("FAIL bp_full_hold[%0d] got r64=%b r32=%b v=%b imm=%h tgt=%h fmt=%0d", k, rdy64, rdy32, ov64, imm64, tgt64, fmt64);
      else n_pass++;
      if (k < 2) step();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      step();
      n_checks++;
      if ({ov64, rdy64, imm64, tgt64, fmt64, tgt32} !==
          {1'b1, 1'b1, e[k].imm64, e[k].tgt64, e[k].fmt64, e[k].tgt32})
        $display("FAIL bp_order[%0d] got v=%b r=%b imm=%h tgt=%h fmt=%0d want imm=%h tgt=%h",
                 k, ov64, rdy64, imm64, tgt64, fmt64, e[k].imm64, e[k].tgt64);
      else n_pass++;
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if ({ov64, ov32} !== 2'b00) $display("FAIL bp_drain got v64=%b v32=%b want 0", ov64, ov32);
    else n_pass++;
  endtask

  task automatic fill_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE112E23; in_pc = 64'h200;
    step();
    in_instr = 32'h800002B7; in_pc = 64'h300;
    step();
  endtask

  task automatic test_flush();
    fill_full();
    in_instr = 32'h001000EF; in_pc = 64'h2000;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({ov64, rdy64, ov32, rdy32} !== 4'b0101)
      $display("FAIL flush got v64=%b r64=%b v32=%b r32=%b want v=0 r=1", ov64, rdy64, ov32, rdy32);
    else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({ov64, ov32} !== 2'b00) $display("FAIL flush_noemit[%0d] got v64=%b v32=%b want 0", k, ov64, ov32);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    fill_full();
    in_valid = 1'b1; in_instr = 32'h001000EF;
    #2 reset = 1'b1;
    #1;
    test_reset();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    e = ref_model(32'hFFF00093, 64'h100);
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h100;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({ov64, imm64, tgt64, fmt64, ov32, tgt32} !== {1'b1, e.imm64, e.tgt64, e.fmt64, 1'b1, e.tgt32})
      $display("FAIL post_reset_accept got v=%b imm=%h tgt=%h fmt=%0d v32=%b tgt32=%h", ov64, imm64, tgt64, fmt64, ov32, tgt32);
    else n_pass++;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    bit in_f, out_f;
    for (int c = 0; c < 1500; c++) begin
      n_checks++;
      if ({ov64, rdy64, ov32, rdy32} !== {q.size() > 0, q.size() < 2, q.size() > 0, q.size() < 2})
        $display("FAIL rnd_hs[%0d] got v64=%b r64=%b v32=%b r32=%b occ=%0d", c, ov64, rdy64, ov32, rdy32, q.size());
      else n_pass++;
      if (q.size() > 0) begin
        n_checks++;
        if ({imm64, tgt64, fmt64, ill64, imm32, tgt32, fmt32, ill32} !== q[0])
          $display("FAIL rnd_data[%0d] got imm=%h tgt=%h fmt=%0d ill=%b imm32=%h tgt32=%h fmt32=%0d ill32=%b want %h",
                   c, imm64, tgt64, fmt64, ill64, imm32, tgt32, fmt32, ill32, q[0]);
        else n_pass++;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_f  = in_valid && (q.size() < 2);
      out_f = out_ready && (q.size() > 0);
      e = ref_model(in_instr, in_pc);
      step();
      if (flush) q.delete();
      else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(e);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
